// File: rtl/rob_cdb_completion_tracker.sv
// ROB completion tracker for one hardware thread: snoops two CDB ports, marks slots done,
// retires up to two slots per cycle in order, and flushes on a retiring mispredict.
module rob_cdb_completion_tracker #(
  parameter int unsigned ROB_SIZE  = 32,
  parameter int unsigned IDX_W     = 5,
  parameter logic        THREAD_ID = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       dispatch_en,
  output logic [IDX_W-1:0] alloc_idx_0,
  output logic [IDX_W-1:0] alloc_idx_1,
  output logic [IDX_W:0]   free_slots,
  output logic             overflow_err,
  input  logic             cdb0_valid,
  input  logic             cdb0_thread,
  input  logic [IDX_W-1:0] cdb0_rob_index,
  input  logic             cdb0_mispredict,
  input  logic             cdb1_valid,
  input  logic             cdb1_thread,
  input  logic [IDX_W-1:0] cdb1_rob_index,
  input  logic             cdb1_mispredict,
  output logic [1:0]       retire_valid,
  output logic [IDX_W-1:0] retire_idx_0,
  output logic [IDX_W-1:0] retire_idx_1,
  output logic             flush,
  output logic [IDX_W-1:0] flush_idx
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_WAIT = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  slot_state_e         slot_q [ROB_SIZE];
  slot_state_e         slot_d [ROB_SIZE];
  logic [ROB_SIZE-1:0] misp_q, misp_d;
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    free_q, free_d;
  logic                ovf_q, ovf_d;

  logic [IDX_W-1:0]    head_p1, tail_p1, flush_slot;
  logic                rv0, rv1, flush_hit;
  logic [1:0]          n_retire, n_req, n_alloc;
  logic                illegal_req, fits, ovf_set;
  logic                cdb0_ok, cdb1_ok;

  // Retire selection from registered state only, so CDB completions need one cycle to retire
  always_comb begin
    head_p1    = head_q + IDX_W'(1);
    rv0        = (slot_q[head_q] == SLOT_DONE);
    rv1        = rv0 && !misp_q[head_q] && (slot_q[head_p1] == SLOT_DONE);
    flush_hit  = (rv0 && misp_q[head_q]) || (rv1 && misp_q[head_p1]);
    flush_slot = (rv0 && misp_q[head_q]) ? head_q : head_p1;
    n_retire   = {1'b0, rv0} + {1'b0, rv1};
  end

  // Dispatch sizing is judged against pre-retire occupancy
  always_comb begin
    tail_p1     = tail_q + IDX_W'(1);
    n_req       = {1'b0, dispatch_en[0]} + {1'b0, dispatch_en[1]};
    illegal_req = (dispatch_en == 2'b10);
    fits        = (CNT_W'(n_req) <= free_q);
    n_alloc     = (!illegal_req && fits) ? n_req : 2'd0;
    ovf_set     = illegal_req || !fits;
    cdb0_ok     = cdb0_valid && (cdb0_thread == THREAD_ID);
    cdb1_ok     = cdb1_valid && (cdb1_thread == THREAD_ID);
  end

  always_comb begin
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      slot_d[i] = slot_q[i];
    end
    misp_d = misp_q;
    head_d = head_q;
    tail_d = tail_q;
    free_d = free_q;
    ovf_d  = ovf_q;
    if (flush_hit) begin
      // Flush drops everything in flight; dispatch and CDB this cycle are discarded
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        slot_d[i] = SLOT_FREE;
      end
      misp_d = '0;
      head_d = flush_slot + IDX_W'(1);
      tail_d = flush_slot + IDX_W'(1);
      free_d = FULL_CNT;
    end else begin
      if (rv0) slot_d[head_q]  = SLOT_FREE;
      if (rv1) slot_d[head_p1] = SLOT_FREE;
      head_d = head_q + IDX_W'(n_retire);
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        if (slot_q[i] == SLOT_WAIT) begin
          if ((cdb0_ok && (cdb0_rob_index == IDX_W'(i))) ||
              (cdb1_ok && (cdb1_rob_index == IDX_W'(i)))) begin
            slot_d[i] = SLOT_DONE;
            misp_d[i] = (cdb0_ok && (cdb0_rob_index == IDX_W'(i)) && cdb0_mispredict) ||
                        (cdb1_ok && (cdb1_rob_index == IDX_W'(i)) && cdb1_mispredict);
          end
        end
      end
      if (n_alloc != 2'd0) begin
        slot_d[tail_q] = SLOT_WAIT;
        misp_d[tail_q] = 1'b0;
      end
      if (n_alloc == 2'd2) begin
        slot_d[tail_p1] = SLOT_WAIT;
        misp_d[tail_p1] = 1'b0;
      end
      tail_d = tail_q + IDX_W'(n_alloc);
      free_d = free_q - CNT_W'(n_alloc) + CNT_W'(n_retire);
      if (ovf_set) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        slot_q[i] <= SLOT_FREE;
      end
      misp_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      free_q <= FULL_CNT;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        slot_q[i] <= slot_d[i];
      end
      misp_q <= misp_d;
      head_q <= head_d;
      tail_q <= tail_d;
      free_q <= free_d;
      ovf_q  <= ovf_d;
    end
  end

  // Retire/flush are suppressed while reset is held
  assign retire_valid = reset ? {rv1, rv0} : 2'b00;
  assign flush        = reset && flush_hit;
  assign flush_idx    = flush_slot;
  assign retire_idx_0 = head_q;
  assign retire_idx_1 = head_p1;
  assign alloc_idx_0  = tail_q;
  assign alloc_idx_1  = tail_p1;
  assign free_slots   = free_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rob_cdb_completion_tracker.sv
// Directed bench for rob_cdb_completion_tracker: expectations queued per step, drained after the edge.
module tb_rob_cdb_completion_tracker;

  localparam int unsigned IDX_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       dispatch_en;
  logic [IDX_W-1:0] alloc_idx_0, alloc_idx_1;
  logic [IDX_W:0]   free_slots;
  logic             overflow_err;
  logic             cdb0_valid, cdb0_thread, cdb0_mispredict;
  logic [IDX_W-1:0] cdb0_rob_index;
  logic             cdb1_valid, cdb1_thread, cdb1_mispredict;
  logic [IDX_W-1:0] cdb1_rob_index;
  logic [1:0]       retire_valid;
  logic [IDX_W-1:0] retire_idx_0, retire_idx_1;
  logic             flush;
  logic [IDX_W-1:0] flush_idx;

  always #5 clock = ~clock;

  rob_cdb_completion_tracker #(.ROB_SIZE(32), .IDX_W(IDX_W), .THREAD_ID(1'b0)) dut (
    .clock(clock), .reset(reset), .dispatch_en(dispatch_en),
    .alloc_idx_0(alloc_idx_0), .alloc_idx_1(alloc_idx_1),
    .free_slots(free_slots), .overflow_err(overflow_err),
    .cdb0_valid(cdb0_valid), .cdb0_thread(cdb0_thread),
    .cdb0_rob_index(cdb0_rob_index), .cdb0_mispredict(cdb0_mispredict),
    .cdb1_valid(cdb1_valid), .cdb1_thread(cdb1_thread),
    .cdb1_rob_index(cdb1_rob_index), .cdb1_mispredict(cdb1_mispredict),
    .retire_valid(retire_valid), .retire_idx_0(retire_idx_0), .retire_idx_1(retire_idx_1),
    .flush(flush), .flush_idx(flush_idx)
  );

  typedef enum int {K_RV, K_R0, K_R1, K_FL, K_FI, K_FREE, K_OVF, K_A0, K_A1} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_RV:    return 32'(retire_valid);
      K_R0:    return 32'(retire_idx_0);
      K_R1:    return 32'(retire_idx_1);
      K_FL:    return 32'(flush);
      K_FI:    return 32'(flush_idx);
      K_FREE:  return 32'(free_slots);
      K_OVF:   return 32'(overflow_err);
      K_A0:    return 32'(alloc_idx_0);
      default: return 32'(alloc_idx_1);
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_en     = 2'b00;
    cdb0_valid      = 1'b0; cdb0_thread = 1'b0; cdb0_rob_index = '0; cdb0_mispredict = 1'b0;
    cdb1_valid      = 1'b0; cdb1_thread = 1'b0; cdb1_rob_index = '0; cdb1_mispredict = 1'b0;
  endtask

  task automatic hit0(input logic [IDX_W-1:0] idx, input logic m, input logic th);
    cdb0_valid = 1'b1; cdb0_rob_index = idx; cdb0_mispredict = m; cdb0_thread = th;
  endtask

  task automatic hit1(input logic [IDX_W-1:0] idx, input logic m, input logic th);
    cdb1_valid = 1'b1; cdb1_rob_index = idx; cdb1_mispredict = m; cdb1_thread = th;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset and first dispatches
    do_reset();
    expect_val("rst_free", K_FREE, 32); expect_val("rst_rv", K_RV, 0);
    expect_val("rst_flush", K_FL, 0);   expect_val("rst_ovf", K_OVF, 0);
    expect_val("rst_a0", K_A0, 0);      expect_val("rst_a1", K_A1, 1);
    check_all();
    dispatch_en = 2'b11; step();
    expect_val("d1_a0", K_A0, 2); expect_val("d1_a1", K_A1, 3); expect_val("d1_free", K_FREE, 30);
    check_all();
    step();
    expect_val("d2_free", K_FREE, 28); expect_val("d2_rv", K_RV, 0); expect_val("d2_a0", K_A0, 4);
    check_all();

    // Out-of-order completion
    idle(); hit1(5'd2, 1'b0, 1'b0); step();
    expect_val("ooo_rv_slot2_only", K_RV, 0);
    check_all();
    idle(); hit0(5'd0, 1'b0, 1'b0); step();
    expect_val("ooo_rv01", K_RV, 1); expect_val("ooo_r0", K_R0, 0);
    check_all();
    idle(); hit0(5'd1, 1'b0, 1'b0); step();
    expect_val("ooo_rv11", K_RV, 3); expect_val("ooo_r0b", K_R0, 1);
    expect_val("ooo_r1b", K_R1, 2); expect_val("ooo_free29", K_FREE, 29);
    check_all();
    idle(); step();
    expect_val("ooo_drain_rv", K_RV, 0); expect_val("ooo_drain_r0", K_R0, 3);
    expect_val("ooo_free31", K_FREE, 31);
    check_all();

    // Mispredict on head slot
    do_reset();
    dispatch_en = 2'b11; step();
    idle(); hit0(5'd0, 1'b1, 1'b0); hit1(5'd1, 1'b0, 1'b0); step();
    expect_val("mp_rv", K_RV, 1); expect_val("mp_flush", K_FL, 1); expect_val("mp_fidx", K_FI, 0);
    check_all();
    idle(); dispatch_en = 2'b10; step();
    expect_val("mp_free", K_FREE, 32); expect_val("mp_tail", K_A0, 1); expect_val("mp_head", K_R0, 1);
    expect_val("mp_rv_after", K_RV, 0); expect_val("mp_fl_after", K_FL, 0);
    expect_val("mp_ovf_discard", K_OVF, 0);
    check_all();

    // Thread filter, duplicate hits, hits on FREE slots
    idle(); dispatch_en = 2'b11; step();
    expect_val("tf_a0", K_A0, 3); expect_val("tf_free", K_FREE, 30);
    check_all();
    idle(); hit0(5'd1, 1'b0, 1'b1); step();
    expect_val("tf_wrong_thread", K_RV, 0);
    check_all();
    idle(); hit0(5'd1, 1'b0, 1'b0); hit1(5'd1, 1'b1, 1'b0); step();
    expect_val("dup_rv", K_RV, 1); expect_val("dup_flush", K_FL, 1); expect_val("dup_fidx", K_FI, 1);
    check_all();
    idle(); step();
    expect_val("dup_free", K_FREE, 32); expect_val("dup_tail", K_A0, 2); expect_val("dup_fl_off", K_FL, 0);
    check_all();
    idle(); dispatch_en = 2'b01; hit0(5'd2, 1'b0, 1'b0); step();
    expect_val("free_hit_rv", K_RV, 0); expect_val("free_hit_free", K_FREE, 31);
    check_all();
    idle(); step();
    expect_val("free_hit_ignored", K_RV, 0);
    check_all();

    // Full, overflow and wrap
    do_reset();
    dispatch_en = 2'b11;
    for (int k = 0; k < 16; k++) step();
    expect_val("full_free", K_FREE, 0); expect_val("full_a0", K_A0, 0); expect_val("full_ovf0", K_OVF, 0);
    check_all();
    dispatch_en = 2'b01; step();
    expect_val("ovf_set", K_OVF, 1); expect_val("ovf_tail", K_A0, 0); expect_val("ovf_free", K_FREE, 0);
    check_all();
    idle(); hit0(5'd0, 1'b0, 1'b0); hit1(5'd1, 1'b0, 1'b0); step();
    expect_val("full_rv", K_RV, 3); expect_val("full_r0", K_R0, 0); expect_val("full_r1", K_R1, 1);
    check_all();
    idle(); dispatch_en = 2'b11; step();
    expect_val("preret_free", K_FREE, 2); expect_val("preret_tail", K_A0, 0);
    expect_val("preret_a1", K_A1, 1);
    check_all();
    step();
    expect_val("reuse_a0", K_A0, 2); expect_val("reuse_free", K_FREE, 0);
    check_all();
    for (int k = 0; k < 15; k++) begin
      idle();
      hit0(5'(2 + 2 * k), 1'b0, 1'b0);
      hit1(5'(3 + 2 * k), 1'b0, 1'b0);
      step();
    end
    expect_val("wrap_rv", K_RV, 3); expect_val("wrap_r0", K_R0, 30);
    expect_val("wrap_r1", K_R1, 31); expect_val("wrap_free", K_FREE, 28);
    check_all();
    idle(); hit0(5'd0, 1'b0, 1'b0); hit1(5'd1, 1'b0, 1'b0); step();
    expect_val("wrap2_rv", K_RV, 3); expect_val("wrap2_r0", K_R0, 0);
    expect_val("wrap2_r1", K_R1, 1); expect_val("wrap2_free", K_FREE, 30);
    check_all();
    idle(); step();
    expect_val("empty_rv", K_RV, 0); expect_val("empty_free", K_FREE, 32);
    expect_val("empty_head", K_R0, 2); expect_val("sticky_ovf", K_OVF, 1);
    check_all();

    // Reset mid-operation
    dispatch_en = 2'b11; step(); step();
    dispatch_en = 2'b01; step();
    expect_val("mid_free", K_FREE, 27); expect_val("mid_a0", K_A0, 7);
    check_all();
    idle(); hit0(5'd2, 1'b0, 1'b0); hit1(5'd3, 1'b0, 1'b0); step();
    expect_val("mid_rv", K_RV, 3); expect_val("mid_r0", K_R0, 2);
    check_all();
    reset = 1'b0; dispatch_en = 2'b11; hit0(5'd4, 1'b1, 1'b0); hit1(5'd5, 1'b0, 1'b0);
    #1;
    expect_val("rst_same_rv", K_RV, 0); expect_val("rst_same_fl", K_FL, 0);
    check_all();
    step();
    expect_val("rst2_free", K_FREE, 32); expect_val("rst2_rv", K_RV, 0);
    expect_val("rst2_fl", K_FL, 0); expect_val("rst2_ovf", K_OVF, 0); expect_val("rst2_a0", K_A0, 0);
    check_all();
    reset = 1'b1; idle(); step();
    expect_val("post_rst_rv", K_RV, 0); expect_val("post_rst_free", K_FREE, 32);
    expect_val("post_rst_head", K_R0, 0);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
